// File: rtl/sky130_sram_ctrl_pkg.sv
// Shared types and default widths for the sky130 1RW port controller.
package sky130_sram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_WMASKS = 4;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_RSP_DEPTH  = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    // The macro masks whole bytes, so the word must be an exact number of lanes.
    function automatic bit widths_ok(input int data_width, input int num_wmasks);
        return data_width == num_wmasks * 8;
    endfunction

endpackage

// File: rtl/sky130_sram_rsp_fifo.sv
// First-word fall-through response FIFO; the head entry is visible whenever valid_o is high.
module sky130_sram_rsp_fifo
    import sky130_sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_RSP_DEPTH,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [CW-1:0]         count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/sky130_sram_1rw_port_ctrl.sv
// Port-0 request front-end for the sky130 32x512 byte-masked OpenRAM macro.
//   state | meaning
//   INIT  | zero-fill sweep, one write per cycle, requests held off
//   RUN   | traffic accepted while response credits remain
module sky130_sram_1rw_port_ctrl
    import sky130_sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS    = DEF_NUM_WMASKS,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH     = DEF_RSP_DEPTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int CU_W  = CW + 1;

    if (!widths_ok(DATA_WIDTH, NUM_WMASKS)) begin : g_width_err
        $error("DATA_WIDTH must equal NUM_WMASKS*8");
    end
    if (RSP_DEPTH < 2) begin : g_depth_err
        $error("RSP_DEPTH must be at least 2");
    end

    ctrl_state_e           state_q, state_d;
    logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;

    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    // Read flags for the request sitting on the pins and the one the macro just sampled.
    logic                  rd_pin_q, rd_pin_d;
    logic                  rd_mac_q;

    logic [CW-1:0]         fifo_count;
    logic [CU_W-1:0]       credits_used;
    logic                  init_issue;
    logic                  accept;
    logic                  rsp_pop;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // With INIT_ON_RESET=0 the INIT state lasts a single cycle and issues nothing.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (!INIT_ON_RESET || init_cnt_q[ADDR_WIDTH]) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign credits_used = CU_W'(fifo_count) + CU_W'(rd_pin_q) + CU_W'(rd_mac_q);
    assign init_issue   = (state_q == ST_INIT) && INIT_ON_RESET && !init_cnt_q[ADDR_WIDTH];

    always_comb begin
        req_ready = (state_q == ST_RUN) && (credits_used < CU_W'(RSP_DEPTH));
        init_done = (state_q == ST_RUN);
        accept    = req_valid && req_ready;
        csb_d     = 1'b1;
        web_d     = web_q;
        wmask_d   = wmask_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rd_pin_d  = 1'b0;
        if (init_issue) begin
            csb_d   = 1'b0;
            web_d   = 1'b0;
            wmask_d = '1;
            addr_d  = init_cnt_q[ADDR_WIDTH-1:0];
            din_d   = '0;
        end else if (accept) begin
            csb_d  = 1'b0;
            addr_d = req_addr;
            if (req_we) begin
                web_d   = 1'b0;
                wmask_d = req_wmask;
                din_d   = req_wdata;
            end else begin
                web_d    = 1'b1;
                rd_pin_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            csb_q    <= 1'b1;
            web_q    <= 1'b1;
            wmask_q  <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            rd_pin_q <= 1'b0;
            rd_mac_q <= 1'b0;
        end else begin
            csb_q    <= csb_d;
            web_q    <= web_d;
            wmask_q  <= wmask_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rd_pin_q <= rd_pin_d;
            rd_mac_q <= rd_pin_q;
        end
    end

    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

    // dout0 is only valid up to the edge after the macro's sampling edge, so capture exactly there.
    assign rsp_pop = rsp_valid && rsp_ready;

    sky130_sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH),
        .CW         (CW)
    ) u_rsp_fifo (
        .clk_i       (clk0),
        .rst_i       (rst0),
        .push_i      (rd_mac_q),
        .push_data_i (sram_dout0),
        .pop_i       (rsp_pop),
        .data_o      (rsp_rdata),
        .valid_o     (rsp_valid),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_sky130_sram_1rw_port_ctrl.sv
// Bench for the sky130 port-0 controller: macro model, transaction-level reference model, directed tests.
module tb_sky130_sram_1rw_port_ctrl;

    localparam int DW    = 32;
    localparam int NM    = 4;
    localparam int AW    = 9;
    localparam int RD    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [NM-1:0] req_wmask = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b1;
    logic          req_ready, rsp_valid, init_done, sram_csb0, sram_web0;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0, rsp_rdata;
    logic [DW-1:0] sram_dout0 = '0;

    always #5 clk0 = ~clk0;

    sky130_sram_1rw_port_ctrl #(
        .DATA_WIDTH (DW), .NUM_WMASKS (NM), .ADDR_WIDTH (AW),
        .RSP_DEPTH (RD), .INIT_ON_RESET (1'b1)
    ) dut (
        .clk0 (clk0), .rst0 (rst0),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_wmask (req_wmask), .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_csb0 (sram_csb0), .sram_web0 (sram_web0), .sram_wmask0 (sram_wmask0),
        .sram_addr0 (sram_addr0), .sram_din0 (sram_din0), .sram_dout0 (sram_dout0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Macro model: samples pins at posedge, writes commit and read data appears at negedge,
    // and dout0 turns to garbage after the following posedge.
    logic [DW-1:0] sram_mem [DEPTH];
    logic          m_csb = 1'b1;
    logic          m_web = 1'b1;
    logic [NM-1:0] m_wmask = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = 32'hC0DE_0000 | i;
    end

    always @(posedge clk0 or negedge clk0) begin
        if (clk0) begin
            m_csb      <= sram_csb0;
            m_web      <= sram_web0;
            m_wmask    <= sram_wmask0;
            m_addr     <= sram_addr0;
            m_din      <= sram_din0;
            sram_dout0 <= 32'hBAD0_BAD0;
        end else if (!m_csb) begin
            if (!m_web) begin
                for (int b = 0; b < NM; b++)
                    if (m_wmask[b]) sram_mem[m_addr][b*8 +: 8] <= m_din[b*8 +: 8];
            end else begin
                sram_dout0 <= sram_mem[m_addr];
            end
        end
    end

    int cyc = 0;
    int rel = 0;
    always @(posedge clk0) begin
        cyc <= cyc + 1;
        rel <= rst0 ? 0 : rel + 1;
    end

    // Reference model: outstanding reads = accepted but not yet consumed; that is the credit pool.
    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_rsp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_rsp_t      exp_q[$];
    bit            acc_last = 1'b0;
    bit            e_init, e_ready, e_valid, e_csb;

    always @(negedge clk0) begin
        if (rst0) begin
            exp_q.delete();
            acc_last = 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            e_init  = (rel >= DEPTH + 1);
            e_ready = e_init && (exp_q.size() < RD);
            e_valid = (exp_q.size() > 0) && ((rel - exp_q[0].acc) >= 2);
            e_csb   = !(acc_last || (rel >= 1 && rel <= DEPTH));
            check("model_init_done", 32'(init_done), 32'(e_init));
            check("model_req_ready", 32'(req_ready), 32'(e_ready));
            check("model_rsp_valid", 32'(rsp_valid), 32'(e_valid));
            check("model_sram_csb0", 32'(sram_csb0), 32'(e_csb));
            if (e_valid) check("model_rsp_rdata", rsp_rdata, exp_q[0].data);
            acc_last = req_valid && e_ready;
            if (e_valid && rsp_ready) void'(exp_q.pop_front());
            if (acc_last) begin
                if (req_we) begin
                    for (int b = 0; b < NM; b++)
                        if (req_wmask[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end else begin
                    exp_q.push_back('{ref_mem[req_addr], rel + 1});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [NM-1:0] mask, output int waits);
        logic r;
        bit   done;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wmask = mask;
        waits = 0;
        done  = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk0);
            r = req_ready;
            tick();
            if (r) done = 1'b1;
            else waits++;
        end
        if (!done) check("issue_timeout", 32'(done), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            lat++;
            if (rsp_valid) seen = 1'b1;
        end
    endtask

    logic [DW-1:0] got_d[$];
    int            got_c[$];

    task automatic collect(input int n);
        got_d.delete();
        got_c.delete();
        for (int k = 0; k < 60 && got_d.size() < n; k++) begin
            @(negedge clk0);
            if (rsp_valid && rsp_ready) begin
                got_d.push_back(rsp_rdata);
                got_c.push_back(cyc);
            end
        end
        check("collect_count", 32'(got_d.size()), 32'(n));
        tick();
    endtask

    task automatic run_init(input string name);
        int  n;
        bit  ready_seen;
        n = 0;
        ready_seen = 1'b0;
        rst0 = 1'b0;
        for (int k = 0; k < DEPTH + 50 && !init_done; k++) begin
            tick();
            n++;
            if (!init_done && req_ready) ready_seen = 1'b1;
        end
        check({name, "_latency"}, 32'(n), 32'(DEPTH + 1));
        check({name, "_ready_low"}, 32'(ready_seen), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lat;

        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_csb0", 32'(sram_csb0), 32'd1);
        check("rst_web0", 32'(sram_web0), 32'd1);
        check("rst_wmask0", 32'(sram_wmask0), 32'd0);
        check("rst_addr0", 32'(sram_addr0), 32'd0);
        check("rst_din0", sram_din0, 32'd0);

        run_init("init1");

        // Last word must have been zero-filled.
        issue(1'b0, 9'h1FF, '0, '0, w);
        wait_rsp(lat);
        check("rd1ff_latency", 32'(lat), 32'd2);
        check("rd1ff_data", rsp_rdata, 32'h0000_0000);

        // Partial-mask overwrite followed immediately by a read of the same word.
        issue(1'b1, 9'h005, 32'hDEAD_BEEF, 4'b1111, w);
        issue(1'b1, 9'h005, 32'h1122_3344, 4'b0101, w);
        issue(1'b0, 9'h005, '0, '0, w);
        wait_rsp(lat);
        check("mask_latency", 32'(lat), 32'd2);
        check("mask_data", rsp_rdata, 32'hDE22_BE44);

        for (int i = 0; i < 6; i++) issue(1'b1, 9'(16 + i), 32'(i), 4'b1111, w);

        // Full-rate reads never run out of credit with four entries.
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(1'b0, 9'(16 + i), '0, '0, w);
                    check("b2b_no_stall", 32'(w), 32'd0);
                end
            end
            collect(4);
        join
        for (int i = 0; i < got_d.size(); i++) begin
            check("b2b_data", got_d[i], 32'(i));
            check("b2b_consecutive", 32'(got_c[i] - got_c[0]), 32'(i));
        end

        // Credit exhaustion under backpressure.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 9'(16 + i), '0, '0, w);
            check("bp_accept", 32'(w), 32'd0);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h014;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk0);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            tick();
        end
        fork
            begin
                issue(1'b0, 9'h014, '0, '0, w);
                check("bp_fifth_wait", 32'(w), 32'd1);
                issue(1'b0, 9'h015, '0, '0, w);
            end
            begin
                rsp_ready = 1'b1;
                collect(6);
            end
        join
        for (int i = 0; i < got_d.size(); i++) check("bp_order", got_d[i], 32'(i));

        // Reset with two reads queued and two in flight.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 9'(16 + i), '0, '0, w);
        check("pre_rst_csb0", 32'(sram_csb0), 32'd0);
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        rst0 = 1'b1;
        #1;
        check("midrst_csb0", 32'(sram_csb0), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        rsp_ready = 1'b1;
        run_init("init2");
        repeat (10) tick();
        check("no_stale_rsp", 32'(rsp_valid), 32'd0);

        // A write with no byte enables is still issued but changes nothing.
        issue(1'b1, 9'h020, 32'hA5A5_A5A5, 4'b1111, w);
        issue(1'b1, 9'h020, 32'h1234_5678, 4'b0000, w);
        check("wm0_csb0", 32'(sram_csb0), 32'd0);
        check("wm0_web0", 32'(sram_web0), 32'd0);
        check("wm0_wmask0", 32'(sram_wmask0), 32'd0);
        check("wm0_addr0", 32'(sram_addr0), 32'h020);
        tick();
        check("wm0_csb0_idle", 32'(sram_csb0), 32'd1);
        issue(1'b0, 9'h020, '0, '0, w);
        wait_rsp(lat);
        check("wm0_latency", 32'(lat), 32'd2);
        check("wm0_data", rsp_rdata, 32'hA5A5_A5A5);

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
